// File: rtl/cv32e40p_secded_pkg.sv
// Shared constants, H matrix and status encoding for the Hsiao (39,32) SEC-DED code.
package cv32e40p_secded_pkg;

  localparam int K = 32;
  localparam int R = 7;
  localparam int N = 39;

  // Row i lists which codeword bits feed syndrome bit i; bit 38 is the leftmost.
  localparam logic [0:6][38:0] H = {
    39'b100011001010010100110010100101010000001,
    39'b010100110010100101001100101001010000010,
    39'b011001001100101001010011001010010000100,
    39'b100110010101001010010100101010100001000,
    39'b101001100010110010100101010010100010000,
    39'b010010011001001100101001010100100100000,
    39'b001100100101010011001010010101001000000
  };

  typedef enum logic [2:0] {
    NONE   = 3'b001,
    CORR   = 3'b010,
    UNCORR = 3'b100
  } secded_status_e;

  // Column j of H, i.e. the syndrome a lone flip of codeword bit j produces.
  function automatic logic [R-1:0] h_col(input int j);
    logic [R-1:0] c;
    c = '0;
    for (int i = 0; i < R; i++) c[i] = H[i][j];
    return c;
  endfunction

endpackage

// File: rtl/cv32e40p_hsiao_secded_syndrome.sv
// Combinational syndrome generator for a 39-bit Hsiao codeword.
module cv32e40p_hsiao_secded_syndrome
  import cv32e40p_secded_pkg::*;
(
  input  logic [N-1:0] cw,
  output logic [R-1:0] syn
);

  always_comb begin
    syn = '0;
    for (int i = 0; i < R; i++) syn[i] = ^(H[i] & cw);
  end

endmodule

// File: rtl/cv32e40p_hsiao_secded_decoder.sv
// Two-stage valid/ready Hsiao SEC-DED decoder with saturating error-event counters.
module cv32e40p_hsiao_secded_decoder
  import cv32e40p_secded_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PAR_WIDTH  = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [DATA_WIDTH+PAR_WIDTH-1:0] data_dec_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [DATA_WIDTH-1:0]           data_dec_o,
  output logic [2:0]                      secded_o,
  output logic [PAR_WIDTH-1:0]            syndrome_o,
  input  logic                            cnt_clear_i,
  output logic [CNT_WIDTH-1:0]            sec_cnt_o,
  output logic [CNT_WIDTH-1:0]            ded_cnt_o,
  output logic [PAR_WIDTH-1:0]            last_syndrome_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Handshake: a word moves across an interface on a cycle where valid and
  // ready are both high; valid never depends on ready, ready_o may depend on ready_i.
  logic s1_valid, s2_valid, s1_en, s2_en, out_hs;
  logic [N-1:0] s1_cw;
  logic [R-1:0] s1_syn, in_syn;
  logic [N-1:0] match, corr_cw;
  secded_status_e s1_status, s2_status;
  logic [K-1:0] s2_data;
  logic [R-1:0] s2_syn;

  assign s2_en   = ~s2_valid | ready_i;
  assign s1_en   = ~s1_valid | s2_en;
  assign ready_o = s1_en;
  assign out_hs  = s2_valid & ready_i;

  cv32e40p_hsiao_secded_syndrome u_syndrome (
    .cw  (data_dec_i),
    .syn (in_syn)
  );

  for (genvar j = 0; j < N; j++) begin : g_col
    assign match[j] = (s1_syn == h_col(j));
  end

  always_comb begin
    corr_cw   = s1_cw;
    s1_status = NONE;
    if (s1_syn != '0) begin
      if (|match) begin
        s1_status = CORR;
        corr_cw   = s1_cw ^ match;
      end else begin
        s1_status = UNCORR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_cw     <= '0;
      s1_syn    <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_status <= NONE;
      s2_syn    <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= valid_i;
        if (valid_i) begin
          s1_cw  <= data_dec_i;
          s1_syn <= in_syn;
        end
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data   <= corr_cw[N-1:R];
          s2_status <= s1_status;
          s2_syn    <= s1_syn;
        end
      end
    end
  end

  // Clear has priority over any increment landing on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt_o       <= '0;
      ded_cnt_o       <= '0;
      last_syndrome_o <= '0;
    end else if (cnt_clear_i) begin
      sec_cnt_o       <= '0;
      ded_cnt_o       <= '0;
      last_syndrome_o <= '0;
    end else if (out_hs) begin
      if (s2_status == CORR && sec_cnt_o != CNT_MAX) sec_cnt_o <= sec_cnt_o + 1'b1;
      if (s2_status == UNCORR && ded_cnt_o != CNT_MAX) ded_cnt_o <= ded_cnt_o + 1'b1;
      if (s2_syn != '0) last_syndrome_o <= s2_syn;
    end
  end

  assign valid_o    = s2_valid;
  assign data_dec_o = s2_data;
  assign secded_o   = s2_status;
  assign syndrome_o = s2_syn;

endmodule

// File: tb/tb_cv32e40p_hsiao_secded_decoder.sv
// Scoreboard bench: drivers push expected words, a negedge monitor pops and compares.
module tb_cv32e40p_hsiao_secded_decoder;

  logic        clk, rst;
  logic        valid_i, ready_o, valid_o, ready_i, cnt_clear_i;
  logic [38:0] data_dec_i;
  logic [31:0] data_dec_o;
  logic [2:0]  secded_o;
  logic [6:0]  syndrome_o, last_syndrome_o;
  logic [15:0] sec_cnt_o, ded_cnt_o;

  cv32e40p_hsiao_secded_decoder #(.DATA_WIDTH(32), .PAR_WIDTH(7), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .data_dec_i(data_dec_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_dec_o(data_dec_o), .secded_o(secded_o),
    .syndrome_o(syndrome_o), .cnt_clear_i(cnt_clear_i), .sec_cnt_o(sec_cnt_o),
    .ded_cnt_o(ded_cnt_o), .last_syndrome_o(last_syndrome_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [38:0] h_row [7];
  initial begin
    h_row[0] = 39'b100011001010010100110010100101010000001;
    h_row[1] = 39'b010100110010100101001100101001010000010;
    h_row[2] = 39'b011001001100101001010011001010010000100;
    h_row[3] = 39'b100110010101001010010100101010100001000;
    h_row[4] = 39'b101001100010110010100101010010100010000;
    h_row[5] = 39'b010010011001001100101001010100100100000;
    h_row[6] = 39'b001100100101010011001010010101001000000;
  end

  function automatic logic [6:0] m_syn(input logic [38:0] cw);
    logic [6:0] s;
    for (int i = 0; i < 7; i++) s[i] = ^(h_row[i] & cw);
    return s;
  endfunction

  // Nearest-codeword search: a single error is one whose flip yields a valid codeword.
  function automatic logic [41:0] m_dec(input logic [38:0] cw);
    logic [6:0]  s;
    logic [38:0] f;
    s = m_syn(cw);
    if (s == 7'd0) return {cw[38:7], 3'b001, s};
    for (int j = 0; j < 39; j++) begin
      f = cw ^ (39'd1 << j);
      if (m_syn(f) == 7'd0) return {f[38:7], 3'b010, s};
    end
    return {cw[38:7], 3'b100, s};
  endfunction

  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [38:0] cw;
    cw = {d, 7'd0};
    cw[6:0] = m_syn(cw);
    return cw;
  endfunction

  // ---------------- scoreboard ----------------
  logic [41:0] exp_q[$];
  int          n_vec, n_fail;
  logic [15:0] m_sec, m_ded;
  logic [6:0]  m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [41:0] e;
    if (!rst) begin
      chk("sec_cnt", 64'(sec_cnt_o), 64'(m_sec));
      chk("ded_cnt", 64'(ded_cnt_o), 64'(m_ded));
      chk("last_syndrome", 64'(last_syndrome_o), 64'(m_last));
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected no word", {data_dec_o, secded_o, syndrome_o});
        end else begin
          chk(ready_i ? "out_word" : "held_word", 64'({data_dec_o, secded_o, syndrome_o}), 64'(exp_q[0]));
          if (ready_i) begin
            e = exp_q.pop_front();
            if (e[9:7] == 3'b010 && m_sec != 16'hFFFF) m_sec++;
            if (e[9:7] == 3'b100 && m_ded != 16'hFFFF) m_ded++;
            if (e[6:0] != 7'd0) m_last = e[6:0];
          end
        end
      end
      if (cnt_clear_i) begin
        m_sec = '0; m_ded = '0; m_last = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_exp(input logic [38:0] cw, input logic [41:0] exp);
    valid_i = 1'b1;
    data_dec_i = cw;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ready_o) begin
        exp_q.push_back(exp);
        @(posedge clk); #1;
        valid_i = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    chk("accept_timeout", 64'd1, 64'(ready_o));
  endtask

  task automatic send(input logic [38:0] cw);
    send_exp(cw, m_dec(cw));
  endtask

  task automatic drain();
    ready_i = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_clear();
    cnt_clear_i = 1'b1;
    @(posedge clk); #1;
    cnt_clear_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic        rand_done;
  logic [38:0] cw;
  int          a, b;

  initial begin
    n_vec = 0; n_fail = 0;
    m_sec = '0; m_ded = '0; m_last = '0;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; cnt_clear_i = 1'b0; data_dec_i = '0;
    rand_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    chk("rst_data", 64'(data_dec_o), 64'd0);
    chk("rst_secded", 64'(secded_o), 64'b001);
    chk("rst_syndrome", 64'(syndrome_o), 64'd0);
    chk("rst_counters", 64'({sec_cnt_o, ded_cnt_o, last_syndrome_o}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Known codewords with hand-derived responses.
    send_exp(39'd0, {32'h0, 3'b001, 7'h00});
    send_exp(39'h80, {32'h0, 3'b010, 7'h07});
    send_exp(39'h01, {32'h0, 3'b010, 7'h01});
    send_exp(39'h81, {32'h1, 3'b100, 7'h06});
    drain();
    chk("dir_sec_cnt", 64'(sec_cnt_o), 64'd2);
    chk("dir_ded_cnt", 64'(ded_cnt_o), 64'd1);
    chk("dir_last_syn", 64'(last_syndrome_o), 64'h06);

    // Backpressure: two accepts fill the pipe, then ready_o drops.
    ready_i = 1'b0;
    send(encode(32'hA5A5_0001));
    send(encode(32'h0000_0002) ^ 39'h100);
    @(negedge clk);
    chk("stall_ready_o", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    fork
      begin
        send(encode(32'h1234_5678) ^ 39'h3);
        send(encode(32'hDEAD_BEEF));
      end
      begin
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random backpressure.
    fork
      begin
        for (int n = 0; n < 600; n++) begin
          cw = encode($urandom);
          case ($urandom_range(0, 3))
            1: cw ^= 39'd1 << $urandom_range(0, 38);
            2: begin
              a = $urandom_range(0, 38);
              b = (a + $urandom_range(1, 38)) % 39;
              cw ^= (39'd1 << a) ^ (39'd1 << b);
            end
            3: cw = {$urandom, $urandom};
            default: ;
          endcase
          send(cw);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Saturation of the corrected-word counter.
    pulse_clear();
    for (int n = 0; n < 65537; n++) send(39'h80);
    drain();
    chk("sat_sec_cnt", 64'(sec_cnt_o), 64'hFFFF);

    // Clear landing on an output handshake of a corrected word.
    fork
      begin
        for (int n = 0; n < 6; n++) send(39'h80);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("clear_hs_valid", 64'(valid_o & ready_i), 64'd1);
        pulse_clear();
        chk("clear_hs_sec_cnt", 64'(sec_cnt_o), 64'd0);
      end
    join
    drain();

    // Reset with words in flight.
    ready_i = 1'b0;
    send(39'h80);
    send(39'h81);
    rst = 1'b1;
    exp_q.delete();
    m_sec = '0; m_ded = '0; m_last = '0;
    @(negedge clk);
    chk("midrst_valid_o", 64'(valid_o), 64'd0);
    chk("midrst_ready_o", 64'(ready_o), 64'd1);
    chk("midrst_counters", 64'({sec_cnt_o, ded_cnt_o, last_syndrome_o}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_i = 1'b1;
    send(encode(32'hCAFE_F00D) ^ (39'd1 << 20));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
